// File: rtl/run_initiator.sv
// Run initiator: launches in_num one-at-a-time run requests, waits for each
// in_done, and faults if the responder stays silent for TIMEOUT cycles.
module run_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_start,
    input  logic [7:0] in_num,
    input  logic       in_done,
    output logic       out_run,
    output logic       out_busy,
    output logic       out_finish,
    output logic       out_timeout,
    output logic [7:0] out_count
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINISH, FAULT} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("run_initiator: TIMEOUT must lie in 2..255");
    end

    state_t     state;
    state_t     next_state;
    logic [7:0] timer;
    logic [7:0] num_latched;
    logic [7:0] count;
    logic       last_run;

    assign last_run = (count + 8'd1) == num_latched;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completion in the same cycle as timer expiry takes priority over the fault.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, FAULT: begin
                if (in_start) begin
                    next_state = (in_num != 8'd0) ? ISSUE : FINISH;
                end
            end
            ISSUE:  next_state = WAIT;
            WAIT: begin
                if (in_done) begin
                    next_state = last_run ? FINISH : ISSUE;
                end else if (timer == TIMER_LAST) begin
                    next_state = FAULT;
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= 8'd0;
            num_latched <= 8'd0;
            count       <= 8'd0;
        end else begin
            case (state)
                IDLE, FAULT: begin
                    if (in_start) begin
                        count <= 8'd0;
                        timer <= 8'd0;
                        if (in_num != 8'd0) begin
                            num_latched <= in_num;
                        end
                    end
                end
                ISSUE: timer <= 8'd0;
                WAIT: begin
                    if (in_done) begin
                        count <= count + 8'd1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_run     = (state == ISSUE);
        out_busy    = (state == ISSUE) || (state == WAIT);
        out_finish  = (state == FINISH);
        out_timeout = (state == FAULT);
        out_count   = count;
    end

endmodule

// File: tb/tb_run_initiator.sv
// Self-checking bench for run_initiator: directed scenarios with literal
// expectations, then randomized traffic compared against a transaction-level model.
module tb_run_initiator;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_start;
    logic [7:0] in_num;
    logic       in_done;
    logic       out_run;
    logic       out_busy;
    logic       out_finish;
    logic       out_timeout;
    logic [7:0] out_count;

    int checks = 0;
    int errors = 0;
    int cntAtRun [8];

    run_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_start   (in_start),
        .in_num     (in_num),
        .in_done    (in_done),
        .out_run    (out_run),
        .out_busy   (out_busy),
        .out_finish (out_finish),
        .out_timeout(out_timeout),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] n, input logic d);
        in_start = s;
        in_num   = n;
        in_done  = d;
    endtask

    // Transaction model: a run request is pending, then a wait of bounded age,
    // then either another request, a finish pulse, or a fault.
    logic m_issue, m_wait, m_finish, m_fault;
    int   m_age, m_done, m_target;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_issue  <= 1'b0;
            m_wait   <= 1'b0;
            m_finish <= 1'b0;
            m_fault  <= 1'b0;
            m_age    <= 0;
            m_done   <= 0;
            m_target <= 0;
        end else if (m_issue) begin
            m_issue <= 1'b0;
            m_wait  <= 1'b1;
            m_age   <= 0;
        end else if (m_wait) begin
            if (in_done) begin
                m_done <= m_done + 1;
                m_wait <= 1'b0;
                if (m_done + 1 == m_target) m_finish <= 1'b1;
                else                        m_issue  <= 1'b1;
            end else if (m_age + 1 == TIMEOUT) begin
                m_wait  <= 1'b0;
                m_fault <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_finish) begin
            m_finish <= 1'b0;
        end else if (in_start) begin
            m_fault  <= 1'b0;
            m_done   <= 0;
            m_target <= int'(in_num);
            if (in_num == 8'd0) m_finish <= 1'b1;
            else                m_issue  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_run",     int'(out_run),     int'(m_issue));
        checkOutput("cmp_busy",    int'(out_busy),    int'(m_issue | m_wait));
        checkOutput("cmp_finish",  int'(out_finish),  int'(m_finish));
        checkOutput("cmp_timeout", int'(out_timeout), int'(m_fault));
        checkOutput("cmp_count",   int'(out_count),   m_done % 256);
    end

    // Responder answers in_done 'delay' cycles after each out_run; optionally
    // pokes in_start in the first WAIT cycle.
    task automatic runSeq(input logic [7:0] num, input int delay, input int budget,
                          input bit midStart, output int runs, output int fins,
                          output int finAt, output int faultAt);
        int since;
        since   = -1;
        runs    = 0;
        fins    = 0;
        finAt   = -1;
        faultAt = -1;
        applyStimulus(1'b1, num, 1'b0);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (out_run) begin
                if (runs < 8) cntAtRun[runs] = int'(out_count);
                runs++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (out_finish) begin
                fins++;
                if (finAt < 0) finAt = cyc;
            end
            if (out_timeout && faultAt < 0) faultAt = since;
            applyStimulus(midStart && since == 1, midStart ? 8'd9 : 8'($urandom),
                          since > 0 && since == delay);
        end
    endtask

    initial begin
        int  runs, fins, finAt, faultAt, since, quiet;
        bit  ok;

        rst = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0);
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_run",     int'(out_run),     0);
        checkOutput("reset_busy",    int'(out_busy),    0);
        checkOutput("reset_finish",  int'(out_finish),  0);
        checkOutput("reset_timeout", int'(out_timeout), 0);
        checkOutput("reset_count",   int'(out_count),   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Three runs, responder replies two cycles after each request.
        runSeq(8'd3, 2, 14, 1'b0, runs, fins, finAt, faultAt);
        checkOutput("seq3_runs",     runs, 3);
        checkOutput("seq3_finishes", fins, 1);
        checkOutput("seq3_fin_at",   finAt, 9);
        checkOutput("seq3_no_fault", faultAt, -1);
        checkOutput("seq3_cnt_run1", cntAtRun[0], 0);
        checkOutput("seq3_cnt_run2", cntAtRun[1], 1);
        checkOutput("seq3_cnt_run3", cntAtRun[2], 2);
        checkOutput("seq3_final_cnt", int'(out_count), 3);

        // Zero-length sequence finishes immediately with no run.
        runSeq(8'd0, 2, 4, 1'b0, runs, fins, finAt, faultAt);
        checkOutput("seq0_runs",   runs, 0);
        checkOutput("seq0_fin_at", finAt, 0);
        checkOutput("seq0_count",  int'(out_count), 0);

        // Silent responder: fault after TIMEOUT cycles of WAIT.
        runSeq(8'd2, 100, 22, 1'b0, runs, fins, finAt, faultAt);
        checkOutput("tmo_runs",     runs, 1);
        checkOutput("tmo_fault_at", faultAt, 17);
        checkOutput("tmo_finishes", fins, 0);
        checkOutput("tmo_timeout",  int'(out_timeout), 1);
        checkOutput("tmo_count",    int'(out_count), 0);

        runSeq(8'd1, 1, 6, 1'b0, runs, fins, finAt, faultAt);
        checkOutput("clr_runs",     runs, 1);
        checkOutput("clr_finishes", fins, 1);
        checkOutput("clr_no_fault", faultAt, -1);
        checkOutput("clr_count",    int'(out_count), 1);

        // Done on the final timer cycle wins; in_start during WAIT is ignored.
        runSeq(8'd1, 16, 22, 1'b1, runs, fins, finAt, faultAt);
        checkOutput("edge_runs",     runs, 1);
        checkOutput("edge_fin_at",   finAt, 17);
        checkOutput("edge_no_fault", faultAt, -1);
        checkOutput("edge_count",    int'(out_count), 1);

        runs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_run) runs++;
            applyStimulus(1'b0, 8'd4, 1'b1);
        end
        @(negedge clk);
        applyStimulus(1'b0, 8'd4, 1'b0);
        checkOutput("idle_done_runs",  runs, 0);
        checkOutput("idle_done_count", int'(out_count), 1);

        // Asynchronous reset in WAIT after two of five completions.
        applyStimulus(1'b1, 8'd5, 1'b0);
        since = -1;
        ok    = 1'b0;
        for (int cyc = 0; cyc < 40 && !ok; cyc++) begin
            @(negedge clk);
            if (out_run) since = 0;
            else if (since >= 0) since++;
            if (out_count == 8'd2 && out_busy && !out_run) ok = 1'b1;
            applyStimulus(1'b0, 8'd5, !ok && since == 2);
        end
        checkOutput("rst_reach_wait", int'(ok), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_run",     int'(out_run),     0);
        checkOutput("rst_busy",    int'(out_busy),    0);
        checkOutput("rst_finish",  int'(out_finish),  0);
        checkOutput("rst_timeout", int'(out_timeout), 0);
        checkOutput("rst_count",   int'(out_count),   0);
        @(negedge clk);
        applyStimulus(1'b0, 8'd5, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 8'd5, 1'b0);
        runs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_run) runs++;
            applyStimulus(1'b0, 8'($urandom), 1'($urandom));
        end
        checkOutput("post_rst_runs",  runs, 0);
        checkOutput("post_rst_busy",  int'(out_busy), 0);
        checkOutput("post_rst_count", int'(out_count), 0);

        // Randomized traffic with quiet stretches that force faults.
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 99) == 0) quiet = 40;
            applyStimulus($urandom_range(0, 7) == 0, 8'($urandom_range(0, 4)),
                          quiet == 0 && $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_initiator.md
RUN_INITIATOR -- requirements
Module: run_initiator

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles in WAIT without in_done before fault; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-high.
REQ-004 in_start  input  1  request to launch a sequence; sampled only in IDLE or FAULT.
REQ-005 in_num  input  8  number of runs in the sequence; sampled with in_start.
REQ-006 in_done  input  1  completion indication from the responder; sampled only in WAIT.
REQ-007 out_run  output  1  one-cycle run request to the responder.
REQ-008 out_busy  output  1  high in ISSUE and WAIT.
REQ-009 out_finish  output  1  one-cycle pulse when the sequence completes.
REQ-010 out_timeout  output  1  high while in FAULT.
REQ-011 out_count  output  8  number of runs completed in the current or last sequence.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, FINISH and FAULT; all outputs are Moore, decoded from registered state/counters.
REQ-013 IDLE or FAULT, in_start=1, in_num!=0: latch in_num, clear out_count and timer, next state ISSUE.
REQ-014 IDLE or FAULT, in_start=1, in_num==0: clear out_count, next state FINISH (no out_run issued).
REQ-015 IDLE or FAULT, in_start=0: remain in the current state; in_done is ignored.
REQ-016 ISSUE: out_run=1 for exactly this one cycle, clear timer, next state WAIT.
REQ-017 WAIT, in_done=1: out_count increments by 1; if the new count equals the latched in_num, next state FINISH; otherwise ISSUE.
REQ-018 WAIT, in_done=0: timer increments; when timer reaches TIMEOUT-1 with in_done still 0, next state FAULT. out_count is held.
REQ-019 Simultaneous in_done=1 and timer expiry in WAIT SHALL be treated as completion; done wins, no fault.
REQ-020 FINISH: out_finish=1 for exactly one cycle, next state IDLE; out_count holds its final value until the next accepted in_start.
REQ-021 FAULT: out_timeout=1 held, out_count frozen, until in_start is accepted per REQ-013/REQ-014.
REQ-022 in_start while busy (ISSUE, WAIT or FINISH) SHALL be ignored; in_num changes mid-sequence have no effect.
REQ-023 Latency: in_start accepted at edge k gives out_run high in the cycle after edge k; in_done sampled at edge m on the final run gives out_finish high in the cycle after edge m.
REQ-024 Timer width is 8 bits; out_count never wraps, because it stops at in_num <= 255.
REQ-025 out_run SHALL never be asserted outside ISSUE; at most one outstanding run at any time.

Reset
REQ-026 rst=1 SHALL force state IDLE, timer=0, latched num=0, out_count=0 and out_run=out_busy=out_finish=out_timeout=0 immediately, independent of clk.
REQ-027 Reset asserted mid-sequence (any state) SHALL abort without further out_run; after release the block waits in IDLE for in_start.
REQ-028 The first edge after rst deassertion SHALL be treated as a normal IDLE cycle.

Verification
REQ-029 in_num=3 with a responder answering in_done 2 cycles after each out_run: 3 out_run pulses, out_count 1,2,3, one out_finish, then IDLE with out_count=3.
REQ-030 in_num=0 with in_start: out_finish pulses the cycle after acceptance, no out_run, out_count=0.
REQ-031 TIMEOUT=16 with in_done held low after the first out_run: FAULT entered 16 cycles after WAIT entry, out_timeout=1, out_count=0; a new in_start with in_num=1 clears the fault and completes normally.
REQ-032 in_done asserted on the exact timer-expiry cycle: completion taken, no out_timeout; in_done pulses in IDLE and in_start pulses during WAIT are both ignored.
REQ-033 rst asserted during WAIT of a 5-run sequence after 2 completions: all outputs read 0 asynchronously; after release, no out_run appears until in_start.
